cordic_iter_ctrl: RTL
=====================

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter DSIZE, 16, data/angle width (signed two's complement).
REQ-002 Parameter ITERS, 14, micro-rotations per operation (legal 1..DSIZE-2).
REQ-003 Parameter ROTTMODE, "ROTT", "ROTT" drives Z to 0; "VECTOR" drives Y to 0.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  request; accepted only while ready=1.
REQ-007 abort  input  1  cancel current operation; no done produced.
REQ-008 Xin, Yin, Zin  input  DSIZE each  operands, sampled on the accepted start cycle.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in ITER.
REQ-011 done  output  1  one-cycle pulse; Xout/Yout/Zout valid that cycle and held until next done.
REQ-012 Xout, Yout, Zout  output  DSIZE each  results.
REQ-013 iter_idx  output  clog2(ITERS)  current micro-rotation index I, for debug/trace.

Function
REQ-014 Angle units: full scale ±pi = ±2^(DSIZE-1); +pi/2 = 2^(DSIZE-2) (16384 at DSIZE=16).
REQ-015 Internal X/Y/Z registers: DSIZE+2 bits, sign-extended on load.
REQ-016 arctan ROM, ITERS entries: atan(2^-i) in angle units, round-to-nearest. DSIZE=16: i0=8192, i1=4836, i2=2555.
REQ-017 FSM states: IDLE, ITER, DONE. Reset state is IDLE.
REQ-018 IDLE with start=1 -> load registers with pre-rotated operands, cnt=0, go to ITER.
REQ-019 ROTT pre-rotation: Zin>2^(DSIZE-2) -> X=-Yin, Y=Xin, Z=Zin-2^(DSIZE-2). Zin<-2^(DSIZE-2) -> X=Yin, Y=-Xin, Z=Zin+2^(DSIZE-2). Otherwise unchanged.
REQ-020 VECTOR pre-rotation, when Xin<0: Yin>=0 -> X=Yin, Y=-Xin, Z=Zin+2^(DSIZE-2). Yin<0 -> X=-Yin, Y=Xin, Z=Zin-2^(DSIZE-2).
REQ-021 Direction per iteration: ROTT d=+1 when Z>=0. VECTOR d=+1 when Y<0.
REQ-022 ITER, each cycle, iteration i=cnt: X<=X-d*(Y>>>i), Y<=Y+d*(X>>>i), Z<=Z-d*atan_i; arithmetic shift, all updates from same-cycle old values.
REQ-023 ITER with cnt=ITERS-1: after the update, go to DONE. Otherwise cnt<=cnt+1.
REQ-024 DONE: register saturated X/Y/Z into outputs and pulse done for 1 cycle. Saturation limits: 2^(DSIZE-1)-1 and -2^(DSIZE-1). Next state is IDLE.
REQ-025 Latency: done asserts exactly ITERS+1 cycles after the accepted start edge. Throughput: one operation per ITERS+2 cycles.
REQ-026 start while not IDLE is ignored, not queued. start in the DONE cycle is ignored.
REQ-027 abort in ITER or DONE -> IDLE next cycle, done stays 0, outputs keep previous values. abort has priority over start in IDLE.
REQ-028 Outputs are not scaled by CORDIC gain K (about 1.6468); gain compensation is downstream.
REQ-029 iter_idx equals cnt in ITER and 0 otherwise.

Reset
REQ-030 rst_n=0 immediately forces: state IDLE, cnt 0, ready 1, busy 0, done 0, Xout/Yout/Zout 0, internal registers 0.
REQ-031 Reset mid-operation discards the operation. The first start after rst_n deasserts is accepted normally.

Verification
REQ-032 ROTT, DSIZE=16, ITERS=14: X=10000, Y=0, Z=8192 -> done at cycle 15; Xout≈11645, Yout≈11645 (±16), |Zout|<=8.
REQ-033 VECTOR: X=10000, Y=10000, Z=0 -> Xout≈23290 (±16), Yout within ±8, Zout≈8192 (±8).
REQ-034 ROTT pre-rotation: X=10000, Y=0, Z=24576 (135°) -> Xout≈-11645, Yout≈11645 (±16).
REQ-035 Saturation: VECTOR X=Y=32767 -> Xout=32767 (clipped), Yout within ±8, no wrap to negative.
REQ-036 start held continuously -> accepts every ITERS+2 cycles; start pulses during busy produce no extra done.
REQ-037 abort at cnt=5 -> no done, ready=1 next cycle. rst_n pulse mid-ITER -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cordic_iter_ctrl_if.sv
// Handshake and operand/result bundle for the iterative CORDIC controller.
// The master side issues operations; the slave side is the CORDIC engine.
interface cordic_iter_ctrl_if #(
    parameter int DSIZE = 16,
    parameter int ITERS = 14
);
    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic                    start;
    logic                    abort;
    logic signed [DSIZE-1:0] Xin;
    logic signed [DSIZE-1:0] Yin;
    logic signed [DSIZE-1:0] Zin;
    logic                    ready;
    logic                    busy;
    logic                    done;
    logic signed [DSIZE-1:0] Xout;
    logic signed [DSIZE-1:0] Yout;
    logic signed [DSIZE-1:0] Zout;
    logic [IW-1:0]           iter_idx;

    modport master (
        output start, abort, Xin, Yin, Zin,
        input  ready, busy, done, Xout, Yout, Zout, iter_idx
    );

    modport slave (
        input  start, abort, Xin, Yin, Zin,
        output ready, busy, done, Xout, Yout, Zout, iter_idx
    );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring
// mode, unscaled (gain K not removed). Supports DSIZE up to 32.
module cordic_iter_ctrl #(
    parameter int    DSIZE    = 16,
    parameter int    ITERS    = 14,
    parameter string ROTTMODE = "ROTT"
) (
    input logic               clock,
    input logic               rst_n,
    cordic_iter_ctrl_if.slave bus
);
    localparam int W   = DSIZE + 2;
    localparam int IW  = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam bit VEC = (ROTTMODE == "VECTOR");

    localparam logic signed [W-1:0] QUARTER = W'(64'sd1 <<< (DSIZE - 2));
    localparam logic signed [W-1:0] SAT_MAX = W'((64'sd1 <<< (DSIZE - 1)) - 64'sd1);
    localparam logic signed [W-1:0] SAT_MIN = W'(-(64'sd1 <<< (DSIZE - 1)));

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       cnt;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic signed [W-1:0] xin_e;
    logic signed [W-1:0] yin_e;
    logic signed [W-1:0] zin_e;
    logic signed [W-1:0] x_ld;
    logic signed [W-1:0] y_ld;
    logic signed [W-1:0] z_ld;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] atan_i;
    logic signed [W-1:0] x_it;
    logic signed [W-1:0] y_it;
    logic signed [W-1:0] z_it;
    logic                dir;
    logic                last;

    logic                    done_q;
    logic signed [DSIZE-1:0] xout_q;
    logic signed [DSIZE-1:0] yout_q;
    logic signed [DSIZE-1:0] zout_q;

    // Table is atan(2^-i) with pi = 2^31; rounded to nearest at DSIZE.
    function automatic logic signed [W-1:0] atan_units(input logic [IW-1:0] i);
        logic [31:0] a;
        logic [33:0] t;
        case (int'(i))
            0:  a = 32'h2000_0000;
            1:  a = 32'h12E4_051E;
            2:  a = 32'h09FB_385B;
            3:  a = 32'h0511_11D4;
            4:  a = 32'h028B_0D43;
            5:  a = 32'h0145_D7E1;
            6:  a = 32'h00A2_F61E;
            7:  a = 32'h0051_7C55;
            8:  a = 32'h0028_BE53;
            9:  a = 32'h0014_5F2F;
            10: a = 32'h000A_2F98;
            11: a = 32'h0005_17CC;
            12: a = 32'h0002_8BE6;
            13: a = 32'h0001_45F3;
            14: a = 32'h0000_A2FA;
            15: a = 32'h0000_517D;
            16: a = 32'h0000_28BE;
            17: a = 32'h0000_145F;
            18: a = 32'h0000_0A30;
            19: a = 32'h0000_0518;
            20: a = 32'h0000_028C;
            21: a = 32'h0000_0146;
            22: a = 32'h0000_00A3;
            23: a = 32'h0000_0051;
            24: a = 32'h0000_0029;
            25: a = 32'h0000_0014;
            26: a = 32'h0000_000A;
            27: a = 32'h0000_0005;
            28: a = 32'h0000_0003;
            29: a = 32'h0000_0001;
            default: a = '0;
        endcase
        t = ({1'b0, a, 1'b0} + (34'd1 << (32 - DSIZE))) >> (33 - DSIZE);
        return W'(t);
    endfunction

    function automatic logic signed [DSIZE-1:0] sat(input logic signed [W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[DSIZE-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DSIZE-1:0];
        else                  return v[DSIZE-1:0];
    endfunction

    assign xin_e = W'(bus.Xin);
    assign yin_e = W'(bus.Yin);
    assign zin_e = W'(bus.Zin);
    assign last  = (cnt == IW'(ITERS - 1));

    // Quarter-turn pre-rotation brings the operand into the +/-99 deg convergence range.
    always_comb begin
        x_ld = xin_e;
        y_ld = yin_e;
        z_ld = zin_e;
        if (VEC) begin
            if (xin_e[W-1]) begin
                if (!yin_e[W-1]) begin
                    x_ld = yin_e;
                    y_ld = -xin_e;
                    z_ld = zin_e + QUARTER;
                end else begin
                    x_ld = -yin_e;
                    y_ld = xin_e;
                    z_ld = zin_e - QUARTER;
                end
            end
        end else begin
            if (zin_e > QUARTER) begin
                x_ld = -yin_e;
                y_ld = xin_e;
                z_ld = zin_e - QUARTER;
            end else if (zin_e < -QUARTER) begin
                x_ld = yin_e;
                y_ld = -xin_e;
                z_ld = zin_e + QUARTER;
            end
        end
    end

    always_comb begin
        x_sh   = x >>> cnt;
        y_sh   = y >>> cnt;
        atan_i = atan_units(cnt);
        dir    = VEC ? y[W-1] : ~z[W-1];
        x_it   = dir ? (x - y_sh)   : (x + y_sh);
        y_it   = dir ? (y + x_sh)   : (y - x_sh);
        z_it   = dir ? (z - atan_i) : (z + atan_i);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.abort) state_nxt = ITER;
            ITER:    if (bus.abort)               state_nxt = IDLE;
                     else if (last)               state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the DONE->IDLE edge, so done is seen in the first IDLE cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            done_q <= 1'b0;
            xout_q <= '0;
            yout_q <= '0;
            zout_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        x   <= x_ld;
                        y   <= y_ld;
                        z   <= z_ld;
                        cnt <= '0;
                    end
                end
                ITER: begin
                    if (!bus.abort) begin
                        x <= x_it;
                        y <= y_it;
                        z <= z_it;
                        if (!last) cnt <= cnt + IW'(1);
                    end
                end
                DONE: begin
                    if (!bus.abort) begin
                        xout_q <= sat(x);
                        yout_q <= sat(y);
                        zout_q <= sat(z);
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = (state == ITER);
    assign bus.done     = done_q;
    assign bus.Xout     = xout_q;
    assign bus.Yout     = yout_q;
    assign bus.Zout     = zout_q;
    assign bus.iter_idx = (state == ITER) ? cnt : '0;
endmodule
